// File: rtl/file_access_arb.sv
// file_access_arb: sequences every access to the single-port file register array.
// Arbitrates between the core datapath and the debug port with a starvation cap,
// resolves INDF (file field 0) through FSR for core accesses, and runs each
// access as read, capture, optional write, then a one-cycle ack to the owner.
module file_access_arb #(
    parameter int AW         = 5,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_inst_f,
    input  logic [AW-1:0] fsr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_ack,
    output logic [DW-1:0] dbg_rdata,
    output logic [AW-1:0] rf_addr,
    output logic          rf_re,
    output logic          rf_we,
    output logic [DW-1:0] rf_wdata,
    input  logic [DW-1:0] rf_rdata,
    output logic          busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          owner_dbg_q, owner_dbg_d;
    logic          we_q, we_d;
    logic          null_q, null_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] core_rdata_q, core_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          dbg_wins;
    logic [AW-1:0] core_eff_addr;

    // Arbitrate in IDLE, latch the winning request, and step through the access phases.
    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        owner_dbg_d   = owner_dbg_q;
        we_d          = we_q;
        null_d        = null_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        core_rdata_d  = core_rdata_q;
        dbg_rdata_d   = dbg_rdata_q;
        dbg_wins      = dbg_req && (!core_req || (starve_q == SW'(STARVE_MAX)));
        core_eff_addr = (core_inst_f != '0) ? core_inst_f : fsr;
        case (state_q)
            IDLE: begin
                if (dbg_wins) begin
                    owner_dbg_d = 1'b1;
                    we_d        = dbg_we;
                    null_d      = 1'b0;
                    addr_d      = dbg_addr;
                    wdata_d     = dbg_wdata;
                    starve_d    = '0;
                    state_d     = RD;
                end else if (core_req) begin
                    owner_dbg_d = 1'b0;
                    we_d        = core_we;
                    // INDF with FSR=0 points nowhere: the access runs but never touches the array.
                    null_d      = (core_inst_f == '0) && (fsr == '0);
                    addr_d      = core_eff_addr;
                    wdata_d     = core_wdata;
                    // Count only core grants that made a waiting debug request wait longer.
                    starve_d    = dbg_req ? starve_q + SW'(1) : '0;
                    state_d     = RD;
                end
            end
            RD: state_d = CAP;
            CAP: begin
                if (owner_dbg_q) begin
                    dbg_rdata_d = null_q ? '0 : rf_rdata;
                end else begin
                    core_rdata_d = null_q ? '0 : rf_rdata;
                end
                state_d = we_q ? WR : DONE;
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Decode array strobes, address/data buses and acks from the current phase.
    always_comb begin
        rf_re      = (state_q == RD) && !null_q;
        rf_we      = (state_q == WR) && !null_q;
        rf_addr    = ((state_q == RD) || (state_q == WR)) ? addr_q : '0;
        rf_wdata   = (state_q == WR) ? wdata_q : '0;
        core_ack   = (state_q == DONE) && !owner_dbg_q;
        dbg_ack    = (state_q == DONE) && owner_dbg_q;
        core_rdata = core_rdata_q;
        dbg_rdata  = dbg_rdata_q;
        busy       = (state_q != IDLE);
    end

    // Control state and the held read-data registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            owner_dbg_q  <= 1'b0;
            we_q         <= 1'b0;
            null_q       <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            owner_dbg_q  <= owner_dbg_d;
            we_q         <= we_d;
            null_q       <= null_d;
            core_rdata_q <= core_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Latched address and write data; only observed while an access is running.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

endmodule

// File: tb/tb_file_access_arb.sv
// Bench for file_access_arb: directed vector table, hand-written arbitration and
// reset sequences, then randomized two-requester traffic against a reference model.
module tb_file_access_arb;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int SM = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_inst_f = '0, fsr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic          dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] rf_addr;
    logic          rf_re, rf_we, busy;
    logic [DW-1:0] rf_wdata, rf_rdata;

    file_access_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_inst_f(core_inst_f), .fsr(fsr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_addr(rf_addr), .rf_re(rf_re), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .busy(busy)
    );

    // File array model: registered read, write on rf_we, plus a backdoor preload port.
    int            cyc = 0;
    logic [DW-1:0] rf_mem [32];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) rf_mem[pre_addr] <= pre_data;
        else if (rf_we) rf_mem[rf_addr] <= rf_wdata;
        if (rf_re) rf_rdata <= rf_mem[rf_addr];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic zero_check(input string name);
        chk(name, {busy, rf_re, rf_we, core_ack, dbg_ack, rf_addr, rf_wdata, core_rdata, dbg_rdata}, 64'd0);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    typedef struct {
        string         name;
        bit            dbg;
        bit            we;
        logic [AW-1:0] f;        // core file field, or debug address
        logic [AW-1:0] fs;
        logic [DW-1:0] wd;
        logic [AW-1:0] pa;       // preloaded location, checked again afterwards
        logic [DW-1:0] pv;
        logic [DW-1:0] exp_rd;
        int            exp_re_off;
        logic [AW-1:0] exp_addr;
        int            exp_we_off;
        int            exp_ack_off;
        logic [DW-1:0] exp_mem;
    } vec_t;

    function automatic vec_t mk(string n, bit d, bit w, logic [AW-1:0] f, logic [AW-1:0] fs,
                                logic [DW-1:0] wd, logic [AW-1:0] pa, logic [DW-1:0] pv,
                                logic [DW-1:0] er, int ero, logic [AW-1:0] ea, int ewo,
                                int eao, logic [DW-1:0] em);
        vec_t v;
        v.name = n; v.dbg = d; v.we = w; v.f = f; v.fs = fs; v.wd = wd; v.pa = pa; v.pv = pv;
        v.exp_rd = er; v.exp_re_off = ero; v.exp_addr = ea; v.exp_we_off = ewo;
        v.exp_ack_off = eao; v.exp_mem = em;
        return v;
    endfunction

    // Runs one isolated access from IDLE; offsets are counted from the grant cycle T.
    task automatic check_vec(input vec_t v);
        int t0, re_off, we_off, ack_off, wrong_ack, re_cnt, we_cnt;
        logic [AW-1:0] re_addr, we_addr;
        logic [DW-1:0] we_data, rd;
        re_off = -1; we_off = -1; ack_off = -1; wrong_ack = 0; re_cnt = 0; we_cnt = 0;
        re_addr = '0; we_addr = '0; we_data = '0;
        preload(v.pa, v.pv);
        t0 = cyc;
        if (v.dbg) begin
            dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.f; dbg_wdata = v.wd;
        end else begin
            core_req = 1'b1; core_we = v.we; core_inst_f = v.f; fsr = v.fs; core_wdata = v.wd;
        end
        for (int i = 0; i < 12 && ack_off < 0; i++) begin
            @(negedge clk);
            if (rf_re) begin re_cnt++; if (re_off < 0) begin re_off = cyc - t0; re_addr = rf_addr; end end
            if (rf_we) begin we_cnt++; if (we_off < 0) begin we_off = cyc - t0; we_addr = rf_addr; we_data = rf_wdata; end end
            if (v.dbg ? dbg_ack : core_ack) ack_off = cyc - t0;
            if (v.dbg ? core_ack : dbg_ack) wrong_ack++;
        end
        rd = v.dbg ? dbg_rdata : core_rdata;
        @(posedge clk); #1;
        core_req = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        chk({v.name, "_ack_off"}, ack_off, v.exp_ack_off);
        chk({v.name, "_rdata"}, rd, v.exp_rd);
        chk({v.name, "_rdata_held"}, v.dbg ? dbg_rdata : core_rdata, v.exp_rd);
        chk({v.name, "_re_off"}, re_off, v.exp_re_off);
        chk({v.name, "_we_off"}, we_off, v.exp_we_off);
        chk({v.name, "_strobe_counts"}, {re_cnt[7:0], we_cnt[7:0]},
            {(v.exp_re_off >= 0) ? 8'd1 : 8'd0, (v.exp_we_off >= 0) ? 8'd1 : 8'd0});
        if (v.exp_re_off >= 0) chk({v.name, "_re_addr"}, re_addr, v.exp_addr);
        if (v.exp_we_off >= 0) chk({v.name, "_we_addr_data"}, {we_addr, we_data}, {v.exp_addr, v.wd});
        chk({v.name, "_other_ack"}, wrong_ack, 0);
        chk({v.name, "_idle_after"}, {busy, core_ack, dbg_ack}, 3'b000);
        chk({v.name, "_mem"}, rf_mem[v.pa], v.exp_mem);
        @(posedge clk); #1;
    endtask

    // Both requesters rise together; records owner and offset of each ack.
    int d_own[$];
    int d_off[$];
    int d_both;
    task automatic dual(input bit drop, input int n);
        int t0;
        bit dc, dd;
        d_own.delete(); d_off.delete(); d_both = 0;
        core_we = 1'b0; dbg_we = 1'b0; core_inst_f = 5'h03; fsr = '0; dbg_addr = 5'h04;
        t0 = cyc;
        core_req = 1'b1; dbg_req = 1'b1;
        for (int i = 0; i < 60 && d_own.size() < n; i++) begin
            @(negedge clk);
            dc = core_ack; dd = dbg_ack;
            if (dc && dd) d_both++;
            if (dc) begin d_own.push_back(0); d_off.push_back(cyc - t0); end
            if (dd) begin d_own.push_back(1); d_off.push_back(cyc - t0); end
            @(posedge clk); #1;
            if (drop && dc) core_req = 1'b0;
            if (drop && dd) dbg_req = 1'b0;
        end
        core_req = 1'b0; dbg_req = 1'b0;
    endtask

    // Reference model for random traffic: each access is atomic at its grant; the
    // observable timeline follows from grant cycle, write flag and null flag.
    logic [DW-1:0] ref_mem [32];
    bit cdone = 1'b0, ddone = 1'b0;

    task automatic monitor();
        bit m_busy = 1'b0, odbg = 1'b0, owe = 1'b0, onull = 1'b0;
        int g = 0, alen = 0, off, run = 0, guard = 0;
        logic [AW-1:0] oaddr = '0, ea;
        logic [DW-1:0] owd = '0, ord = '0, ew;
        logic [17:0] exp_v, act_v;
        while (!(cdone && ddone && !m_busy) && guard < 6000) begin
            @(negedge clk);
            guard++;
            act_v = {busy, rf_re, rf_we, core_ack, dbg_ack, rf_addr, rf_wdata};
            if (!m_busy) begin
                exp_v = '0;
                if (core_req || dbg_req) begin
                    odbg = dbg_req && (!core_req || run == SM);
                    if (odbg || !dbg_req) run = 0;
                    else run++;
                    if (odbg) begin
                        owe = dbg_we; oaddr = dbg_addr; owd = dbg_wdata; onull = 1'b0;
                    end else begin
                        owe = core_we; owd = core_wdata;
                        oaddr = (core_inst_f != '0) ? core_inst_f : fsr;
                        onull = (core_inst_f == '0) && (fsr == '0);
                    end
                    ord = onull ? 8'h00 : ref_mem[oaddr];
                    if (owe && !onull) ref_mem[oaddr] = owd;
                    g = cyc; alen = owe ? 4 : 3; m_busy = 1'b1;
                end
            end else begin
                off = cyc - g;
                ea = (off == 1 || (owe && off == 3)) ? oaddr : '0;
                ew = (owe && off == 3) ? owd : '0;
                exp_v = {1'b1, (off == 1) && !onull, owe && !onull && off == 3,
                         !odbg && off == alen, odbg && off == alen, ea, ew};
                if (off == alen) begin
                    chk(odbg ? "rand_dbg_rdata" : "rand_core_rdata", odbg ? dbg_rdata : core_rdata, ord);
                    m_busy = 1'b0;
                end
            end
            chk("rand_cycle", act_v, exp_v);
        end
        chk("rand_monitor_finished", guard < 6000, 1'b1);
    endtask

    task automatic rand_core_fields();
        core_we     = 1'($urandom_range(0, 1));
        core_inst_f = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
        fsr         = ($urandom_range(0, 3) == 0) ? 5'h00 : 5'($urandom_range(0, 31));
        core_wdata  = 8'($urandom);
    endtask

    task automatic rand_dbg_fields();
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 5'($urandom_range(0, 31));
        dbg_wdata = 8'($urandom);
    endtask

    task automatic core_drv(input int n);
        int w;
        bit seen;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            core_req = 1'b1;
            rand_core_fields();
            w = 0; seen = 1'b0;
            while (!seen && w < 40) begin
                @(negedge clk); w++;
                if (core_ack) seen = 1'b1;
                else begin @(posedge clk); #1; if ($urandom_range(0, 1) == 1) rand_core_fields(); end
            end
            chk("rand_core_ack_within_bound", seen, 1'b1);
            @(posedge clk); #1;
            if ($urandom_range(0, 2) == 0) begin
                core_req = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        core_req = 1'b0;
    endtask

    task automatic dbg_drv(input int n);
        int w;
        bit seen;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            dbg_req = 1'b1;
            rand_dbg_fields();
            w = 0; seen = 1'b0;
            while (!seen && w < 40) begin
                @(negedge clk); w++;
                if (dbg_ack) seen = 1'b1;
                else begin @(posedge clk); #1; if ($urandom_range(0, 1) == 1) rand_dbg_fields(); end
            end
            chk("rand_dbg_ack_within_bound", seen, 1'b1);
            @(posedge clk); #1;
            if ($urandom_range(0, 1) == 0) begin
                dbg_req = 1'b0;
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1;
            end
        end
        dbg_req = 1'b0;
    endtask

    vec_t vecs[9];
    int   bad;
    int   late_acks;

    initial begin
        vecs[0] = mk("direct_rd",      0, 0, 5'h0C, 5'h00, 8'h00, 5'h0C, 8'h5A, 8'h5A,  1, 5'h0C, -1, 3, 8'h5A);
        vecs[1] = mk("indirect_wr",    0, 1, 5'h00, 5'h11, 8'hA5, 5'h11, 8'h33, 8'h33,  1, 5'h11,  3, 4, 8'hA5);
        vecs[2] = mk("null_wr",        0, 1, 5'h00, 5'h00, 8'h77, 5'h00, 8'h99, 8'h00, -1, 5'h00, -1, 4, 8'h99);
        vecs[3] = mk("null_rd",        0, 0, 5'h00, 5'h00, 8'h00, 5'h00, 8'h99, 8'h00, -1, 5'h00, -1, 3, 8'h99);
        vecs[4] = mk("direct_wr_fsr",  0, 1, 5'h1F, 5'h03, 8'hC3, 5'h1F, 8'h81, 8'h81,  1, 5'h1F,  3, 4, 8'hC3);
        vecs[5] = mk("indirect_rd_1f", 0, 0, 5'h00, 5'h1F, 8'h00, 5'h1F, 8'hE7, 8'hE7,  1, 5'h1F, -1, 3, 8'hE7);
        vecs[6] = mk("direct_f1_fsr0", 0, 0, 5'h01, 5'h00, 8'h00, 5'h01, 8'h42, 8'h42,  1, 5'h01, -1, 3, 8'h42);
        vecs[7] = mk("dbg_wr_addr0",   1, 1, 5'h00, 5'h00, 8'h5C, 5'h00, 8'h11, 8'h11,  1, 5'h00,  3, 4, 8'h5C);
        vecs[8] = mk("dbg_rd",         1, 0, 5'h0A, 5'h00, 8'h00, 5'h0A, 8'hB4, 8'hB4,  1, 5'h0A, -1, 3, 8'hB4);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        zero_check("reset_outputs");
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 9; i++) check_vec(vecs[i]);

        // Starvation: both held high, all reads
        dual(1'b0, 8);
        chk("starve_ack_count", d_own.size(), 8);
        for (int i = 0; i < 8 && i < d_own.size(); i++) begin
            chk($sformatf("starve_owner_%0d", i), d_own[i], (i % 4 == 3) ? 1 : 0);
            chk($sformatf("starve_off_%0d", i), d_off[i], 4 * i + 3);
        end
        chk("starve_no_joint_ack", d_both, 0);
        @(posedge clk); #1;

        // Tie from empty: each side drops after its own ack
        dual(1'b1, 2);
        late_acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (core_ack || dbg_ack) late_acks++;
        end
        @(posedge clk); #1;
        chk("tie_ack_count", d_own.size(), 2);
        if (d_own.size() == 2) begin
            chk("tie_first_owner_core", {d_own[0][7:0], d_off[0][7:0]}, {8'd0, 8'd3});
            chk("tie_second_owner_dbg", {d_own[1][7:0], d_off[1][7:0]}, {8'd1, 8'd7});
        end
        chk("tie_no_joint_ack", d_both, 0);
        chk("tie_no_extra_ack", late_acks, 0);

        // Reset during CAP of a write access
        preload(5'h05, 8'h6E);
        core_req = 1'b1; core_we = 1'b1; core_inst_f = 5'h05; fsr = '0; core_wdata = 8'h11;
        bad = 0;
        @(negedge clk); bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        @(posedge clk); #1;
        @(negedge clk); bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk); bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        @(posedge clk); #1;
        @(negedge clk);
        zero_check("reset_mid_outputs");
        bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        @(posedge clk); #1;
        core_req = 1'b0;
        @(negedge clk); bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk); bad += int'(rf_we) + int'(core_ack) + int'(dbg_ack);
        end
        @(posedge clk); #1;
        chk("reset_mid_no_we_no_ack", bad, 0);
        chk("reset_mid_mem_untouched", rf_mem[5], 8'h6E);
        check_vec(mk("post_reset_rd", 0, 0, 5'h05, 5'h00, 8'h00, 5'h05, 8'h6E, 8'h6E, 1, 5'h05, -1, 3, 8'h6E));

        // Randomized contention against the reference model
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = rf_mem[i];
        fork
            begin core_drv(70); cdone = 1'b1; end
            begin dbg_drv(50); ddone = 1'b1; end
            monitor();
        join
        for (int i = 0; i < 32; i++) chk($sformatf("rand_mem_%0d", i), rf_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/file_access_arb.md
Name: file_access_arb

Overview:
- Sequences every access to the 32-entry file register array.
- Shares the array's single port between the core datapath and the debug/host port.
- Resolves the effective file address for core accesses: direct from the instruction's 5-bit file field; indirect through FSR when that field is 0 (INDF).
- Runs each access as a read phase, then an optional write phase, and returns read data with a one-cycle ack.

Parameters:
AW, 5, file address width
DW, 8, file data width
STARVE_MAX, 3, max consecutive core grants while dbg_req is pending before debug is forced in

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
core_req  in  1  core access request; level, held until core_ack
core_we  in  1  core access includes write phase
core_inst_f  in  AW  instruction file field; 0 selects indirect
fsr  in  AW  FSR value used for indirect addressing
core_wdata  in  DW  core write data
core_ack  out  1  one-cycle completion pulse to core
core_rdata  out  DW  data read in this access; valid with core_ack, held until next capture
dbg_req  in  1  debug request; level, held until dbg_ack
dbg_we  in  1  debug access includes write phase
dbg_addr  in  AW  debug file address (always direct)
dbg_wdata  in  DW  debug write data
dbg_ack  out  1  one-cycle completion pulse to debug
dbg_rdata  out  DW  debug read data; valid with dbg_ack, held
rf_addr  out  AW  file array address
rf_re  out  1  file array read strobe
rf_we  out  1  file array write strobe
rf_wdata  out  DW  file array write data
rf_rdata  in  DW  file array read data; valid the cycle after rf_re
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, starve count=0, every output=0 (including held rdata registers).
- Reset mid-access aborts the access: no rf_we and no ack for it.
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE: arbitrate and latch the winner's owner, address, we and wdata, then go to RD. Later requester input changes are ignored until DONE.
- Arbitration:
  - Core wins by default.
  - Debug wins if core_req=0, or if starve count == STARVE_MAX.
  - Starve count increments on each core grant while dbg_req=1. It clears on a debug grant, or on any grant when dbg_req=0.
- Effective core address: core_inst_f != 0 -> core_inst_f; otherwise fsr.
- Null indirect: core_inst_f==0 and fsr==0.
  - rf_re and rf_we stay 0.
  - Captured read data = 0.
  - The access still walks RD->CAP->(WR)->DONE with identical timing.
- RD: rf_re=1, rf_addr=latched address, for one cycle.
- CAP: capture rf_rdata into the owner's rdata register. Next state is WR if latched we=1, else DONE.
- WR: rf_we=1, rf_addr=latched address, rf_wdata=latched wdata, for one cycle.
- DONE: owner's ack=1 for one cycle, then IDLE.
  - A requester whose req is still high in IDLE after its ack is treated as a new request.
- Latency, grant cycle T (the IDLE cycle):
  - Read-only access: ack at T+3.
  - Access with write: ack at T+4.
  - Back-to-back throughput: one access per 4 cycles (read) or 5 cycles (write), including the IDLE cycle.
- rf_addr, rf_wdata = 0 when not in RD or WR.
- rdata is the value before the write (read-modify-write semantics). The write is committed before ack.
- Simultaneous core_req and dbg_req in IDLE: the arbitration rule above decides; the loser waits and is not acked.
- Input widths are exact; no truncation or extension.

Test Plan:
- Direct read: rf[0x0C]=0x5A; core_req, core_we=0, core_inst_f=0x0C.
  -> rf_re at T+1 with rf_addr=0x0C; core_ack at T+3; core_rdata=0x5A; rf_we never asserted.
- Indirect write: core_inst_f=0, fsr=0x11, core_we=1, core_wdata=0xA5, rf[0x11]=0x33.
  -> core_rdata=0x33; rf_we at T+3 with rf_addr=0x11 and rf_wdata=0xA5; core_ack at T+4; rf[0x11]=0xA5.
- Null indirect: core_inst_f=0, fsr=0, core_we=1.
  -> rf_re=rf_we=0 throughout; core_rdata=0x00; core_ack at T+4.
- Starvation: core_req and dbg_req held high continuously, STARVE_MAX=3, all reads.
  -> grants in order core, core, core, dbg, core, ...; dbg_ack on the 4th completion.
- Arbitration tie from empty: core_req and dbg_req rise together.
  -> core granted first; dbg granted in the next IDLE; both acked once; acks never in the same cycle.
- Reset mid-access: assert rst_n=0 during CAP of a write access.
  -> no rf_we, no ack; all outputs 0 the cycle after the edge; a new request after release completes normally.
